pixel_clip_fifo: RTL and testbench
==================================

# pixel_clip_fifo

Downstream stage between the circle rasterizer and the VGA adapter plot port. Accepts one candidate pixel per cycle from the rasterizer and discards pixels outside the 160x120 screen. Surviving pixels are queued in a small FIFO and drained to the adapter under an `out_ready` handshake. The drawer's `done` is forwarded only after every accepted pixel has been handed off.

## Interface
Parameters:
- `DEPTH`, 8, number of FIFO entries; power of two, ≥2.
- `SCREEN_W`, 160, number of valid x columns (0..SCREEN_W-1).
- `SCREEN_H`, 120, number of valid y rows (0..SCREEN_H-1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_plot`  in  1  candidate pixel valid this cycle.
- `in_x`  in  9  candidate x, two's complement (pre-truncation drawer coordinate).
- `in_y`  in  8  candidate y, two's complement.
- `in_colour`  in  3  candidate colour.
- `in_done`  in  1  drawer done level.
- `out_ready`  in  1  adapter accepts the head pixel this cycle.
- `vga_x`  out  8  head pixel x.
- `vga_y`  out  7  head pixel y.
- `vga_colour`  out  3  head pixel colour.
- `vga_plot`  out  1  head pixel valid.
- `done`  out  1  drawer finished and FIFO drained.
- `overflow`  out  1  sticky flag: an in-range pixel was dropped because the FIFO was full.
- `clipped_count`  out  16  saturating count of out-of-range pixels.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **In-range test:** signed compare, `0 ≤ in_x ≤ SCREEN_W-1` and `0 ≤ in_y ≤ SCREEN_H-1`.
  - A negative value is out of range; no wrap-around is permitted.
  - Stored x/y are the low 8 and 7 bits.
- **Pop:** occurs when `vga_plot && out_ready`.
- **Push:** occurs when `in_plot`, the pixel is in range, and (`fifo_level < DEPTH` or a pop occurs this cycle).
- **Full, no pop:** in-range pixel is dropped; `overflow` ← 1, held until reset.
- **Out of range:** an `in_plot` pixel outside the screen is never stored. `clipped_count` increments and saturates at 16'hFFFF.
- **Ordering:** FIFO order is strict, first in first out.
- **Level update:** simultaneous push and pop leaves `fifo_level` unchanged.
- **Head outputs:**
  - Non-empty: `vga_plot` = 1 and `vga_x`/`vga_y`/`vga_colour` show the head entry (show-ahead).
  - Empty: all four outputs are 0.
- **Done FSM**, states IDLE, DRAIN, DONE:
  - IDLE: `done` = 0; `in_done` = 1 → DRAIN.
  - DRAIN: `done` = 0. FIFO empty after this edge and no push this cycle → DONE. `in_done` falls → IDLE.
  - DONE: `done` = 1. `in_done` = 0 → IDLE. A push while in DONE → DRAIN, so `done` is never high with pixels pending.
- **Reset (including mid-drain):** FIFO emptied, state IDLE, counters and flags cleared. In-flight pixels are discarded.

## Timing
- Reset values: `vga_plot`, `vga_x`, `vga_y`, `vga_colour`, `done`, `overflow`, `clipped_count`, `fifo_level` all 0.
- Latency: a pixel pushed at edge N into an empty FIFO gives `vga_plot` = 1 in the cycle after edge N, so throughput is one pixel per cycle. With `out_ready` held high, each pixel is presented for exactly one cycle.
- The head outputs change only on clock edges; they are functions of registered state only.
- `done` rises one edge after the edge on which the FIFO becomes empty with `in_done` high. It falls one edge after `in_done` falls.
- `overflow` and `clipped_count` update on the edge following the offending `in_plot` cycle.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-operation with 5 entries queued → all outputs 0 immediately; FIFO empty after release.
- **Single pixel:** `in_plot` (80, 60, colour 3'b100) for one cycle, `out_ready` = 1 → next cycle `vga_plot` = 1 at (80, 60, 4); the following cycle `vga_plot` = 0 and `fifo_level` = 0.
- **Clipping:** `in_x` = 160, then `in_x` = 9'h1FF (−1), then `in_y` = 120, each in-range on the other axis → `vga_plot` never 1 and `clipped_count` = 3.
- **Backpressure:** `out_ready` = 0, push 10 distinct in-range pixels (DEPTH = 8) → `fifo_level` = 8 and `overflow` = 1 after the 9th. Then `out_ready` = 1 → the first 8 pixels emerge in order, one per cycle.
- **Full with simultaneous push/pop:** level 8, `out_ready` = 1 and an in-range push in the same cycle → pixel accepted, level stays 8, `overflow` stays 0.
- **Done:** 3 pixels queued, `in_done` = 1, `out_ready` = 1 → `done` = 1 exactly one cycle after the third pop. Then `in_done` = 0 → `done` = 0 the next cycle. An `in_plot` in DONE → `done` drops until that pixel drains.

Source files
------------

// File: rtl/pixel_clip_fifo.sv
// Screen clipper and show-ahead pixel FIFO between the circle rasterizer and the VGA plot port.
// Forwards the drawer's done only once every accepted pixel has been handed to the adapter.
module pixel_clip_fifo #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_plot,
    input  logic [8:0]               in_x,
    input  logic [7:0]               in_y,
    input  logic [2:0]               in_colour,
    input  logic                     in_done,
    input  logic                     out_ready,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     done,
    output logic                     overflow,
    output logic [15:0]              clipped_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [17:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q;
    logic [15:0]   clip_cnt_q;
    state_t        state_q, state_d;

    logic signed [8:0] x_s;
    logic signed [7:0] y_s;
    logic              in_range, head_vld, full, pop, push, drop, clip;
    logic [17:0]       head;

    // Sign-extend before comparing so negative coordinates never alias onto the screen.
    assign x_s      = in_x;
    assign y_s      = in_y;
    assign in_range = (int'(x_s) >= 0) && (int'(x_s) < SCREEN_W) &&
                      (int'(y_s) >= 0) && (int'(y_s) < SCREEN_H);

    assign head_vld = (level_q != '0);
    assign full     = (level_q == LW'(DEPTH));
    assign pop      = head_vld && out_ready;
    assign push     = in_plot && in_range && (!full || pop);
    assign drop     = in_plot && in_range && full && !pop;
    assign clip     = in_plot && !in_range;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            if (drop) overflow_q <= 1'b1;
            if (clip) clip_cnt_q <= sat_inc16(clip_cnt_q);
        end
    end

    // Storage needs no reset: an entry is only visible once the level covers it.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {in_x[7:0], in_y[6:0], in_colour};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_done) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!in_done)
                    state_d = S_IDLE;
                else if (level_q == '0 && !push)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (!in_done)
                    state_d = S_IDLE;
                else if (push)
                    state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        vga_plot   = head_vld;
        vga_x      = head_vld ? head[17:10] : 8'd0;
        vga_y      = head_vld ? head[9:3]   : 7'd0;
        vga_colour = head_vld ? head[2:0]   : 3'd0;
        done       = (state_q == S_DONE);
    end

    assign overflow      = overflow_q;
    assign clipped_count = clip_cnt_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Directed bench for pixel_clip_fifo: vector table for clipping/single-pixel flow,
// hand sequences for backpressure, reset, full push/pop and the done handshake.
module tb_pixel_clip_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_plot = 1'b0;
    logic [8:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        in_done = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        done;
    logic        overflow;
    logic [15:0] clipped_count;
    logic [3:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    pixel_clip_fifo #(.DEPTH(8), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .rst_n(rst_n), .in_plot(in_plot), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .in_done(in_done), .out_ready(out_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .done(done), .overflow(overflow), .clipped_count(clipped_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    logic [40:0] snap;
    logic [18:0] head;
    assign snap = {vga_plot, vga_x, vga_y, vga_colour, done, overflow, clipped_count, fifo_level};
    assign head = {vga_plot, vga_x, vga_y, vga_colour};

    typedef struct {
        logic        plot;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic        rdy;
        logic        e_plot;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_c;
        logic [15:0] e_clip;
        logic [3:0]  e_lvl;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] pix(input int i);
        return {8'(10 + i), 7'(20 + i), 3'(i)};
    endfunction

    task automatic put(input logic [17:0] p);
        in_plot   = 1'b1;
        in_x      = {1'b0, p[17:10]};
        in_y      = {1'b0, p[9:3]};
        in_colour = p[2:0];
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 9'd80,   8'd60,   3'd4, 1'b1, 1'b1, 8'd80,  7'd60,  3'd4, 16'd0, 4'd1};
        tbl[1]  = '{1'b0, 9'd0,    8'd0,    3'd0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd0, 4'd0};
        tbl[2]  = '{1'b1, 9'd160,  8'd60,   3'd1, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 16'd1, 4'd0};
        tbl[3]  = '{1'b1, 9'h1FF,  8'd60,   3'd1, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 16'd2, 4'd0};
        tbl[4]  = '{1'b1, 9'd10,   8'd120,  3'd1, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 16'd3, 4'd0};
        tbl[5]  = '{1'b1, 9'd0,    8'd0,    3'd7, 1'b0, 1'b1, 8'd0,   7'd0,   3'd7, 16'd3, 4'd1};
        tbl[6]  = '{1'b1, 9'd159,  8'd119,  3'd2, 1'b0, 1'b1, 8'd0,   7'd0,   3'd7, 16'd3, 4'd2};
        tbl[7]  = '{1'b0, 9'd0,    8'd0,    3'd0, 1'b1, 1'b1, 8'd159, 7'd119, 3'd2, 16'd3, 4'd1};
        tbl[8]  = '{1'b0, 9'd0,    8'd0,    3'd0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd3, 4'd0};
        tbl[9]  = '{1'b1, 9'd5,    8'h80,   3'd5, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 16'd4, 4'd0};
        tbl[10] = '{1'b1, 9'h100,  8'd5,    3'd6, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 16'd5, 4'd0};

        // Reset state
        step();
        chk("reset_outputs", 64'(snap), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("after_release", 64'(snap), 64'd0);

        // Single pixel, clipping and show-ahead ordering
        for (int i = 0; i < 11; i++) begin
            in_plot   = tbl[i].plot;
            in_x      = tbl[i].x;
            in_y      = tbl[i].y;
            in_colour = tbl[i].c;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d", i), 64'(snap),
                64'({tbl[i].e_plot, tbl[i].e_x, tbl[i].e_y, tbl[i].e_c, 1'b0, 1'b0,
                     tbl[i].e_clip, tbl[i].e_lvl}));
        end

        // Backpressure: ten pushes into eight slots, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            put(pix(i));
            step();
            chk($sformatf("bp_level%0d", i), 64'(fifo_level), (i < 8) ? 64'(i + 1) : 64'd8);
            chk($sformatf("bp_ovf%0d", i), 64'(overflow), (i >= 8) ? 64'd1 : 64'd0);
        end
        in_plot   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_head%0d", k), 64'(head), 64'({1'b1, pix(k)}));
            step();
        end
        chk("bp_empty", 64'({vga_plot, fifo_level}), 64'd0);

        // Asynchronous reset with five entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(pix(20 + i));
            step();
        end
        in_plot = 1'b0;
        chk("rst_level5", 64'(fifo_level), 64'd5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 64'(snap), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_empty_after", 64'({vga_plot, fifo_level}), 64'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            put(pix(30 + i));
            step();
        end
        chk("full_level", 64'({overflow, fifo_level}), 64'd8);
        put(pix(40));
        out_ready = 1'b1;
        step();
        chk("full_pushpop_level", 64'({overflow, fifo_level}), 64'd8);
        in_plot = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full_head%0d", k), 64'(head),
                64'({1'b1, (k < 7) ? pix(31 + k) : pix(40)}));
            step();
        end
        chk("full_empty", 64'({vga_plot, fifo_level}), 64'd0);

        // Done handshake
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(pix(45 + i));
            step();
        end
        in_plot   = 1'b0;
        in_done   = 1'b1;
        out_ready = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk($sformatf("done_low_pop%0d", e), 64'(done), 64'd0);
        end
        chk("done_fifo_empty", 64'(vga_plot), 64'd0);
        step();
        chk("done_rise", 64'(done), 64'd1);
        in_done = 1'b0;
        step();
        chk("done_fall", 64'(done), 64'd0);
        in_done = 1'b1;
        step();
        chk("done_redrain", 64'(done), 64'd0);
        step();
        chk("done_rerise", 64'(done), 64'd1);
        put(pix(50));
        step();
        chk("done_push_drop", 64'({done, vga_plot}), 64'b01);
        in_plot = 1'b0;
        step();
        chk("done_pending_popped", 64'({done, vga_plot}), 64'b00);
        step();
        chk("done_after_drain", 64'(done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
